cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Parametrised multicycle control sequencer; successor to the fixed 4-state RESET/FETCH/DECODE/EXECUTE controller in the cpu top.
- Owns the PC and the instruction-cycle FSM.
- Adds handshaked instruction/data memory access, absolute or PC-relative branching, halt with resume, memory-timeout fault, and a retired-instruction counter.
- Sits between instrMem/dataMem and Control_Unit; drives their enables.

Parameters:
- PC_W, 10, PC and branch-address width.
- RESET_VEC, 0, PC value loaded on reset.
- BRA_REL, 0, 0 = badr is absolute target; 1 = badr is signed offset added to current PC.
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before FAULT; 0 disables timeout.
- CNT_W, 16, retired-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction word valid.
- ir_load  out  1  capture IR strobe.
- cu_en  out  1  decode strobe to Control_Unit.
- bra  in  1  branch taken; sampled in DECODE.
- hlt  in  1  halt instruction; sampled in DECODE.
- badr  in  PC_W  branch target or offset.
- mem_op  in  1  current instruction needs dataMem; sampled in EXECUTE.
- exec_en  out  1  execute strobe (ALU/mov/reg write).
- mem_req  out  1  data memory request.
- mem_ack  in  1  data memory done.
- resume  in  1  leave HALT.
- pc  out  PC_W  current PC.
- st  out  3  FSM state code.
- halted  out  1  in HALT.
- fault  out  1  in FAULT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
Reset (rst=0, any time, including mid-operation):
- st=RESET, pc=RESET_VEC, retired=0, timeout counter=0.
- All strobes/flags 0.

State codes: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_WAIT=4, HALT=5, FAULT=6. Code 7 → RESET next cycle.

Strobes and flags:
- All are combinational decodes of the registered state (plus ack where noted).
- No other outputs change outside state transitions.

Transitions:
- RESET: no strobes; → FETCH next cycle after rst deasserts.
- FETCH:
  - imem_req=1 every cycle in FETCH.
  - ir_load = imem_ack (Mealy).
  - On imem_ack → DECODE; else stay.
- DECODE: cu_en=1 for exactly one cycle. Priority, first match wins:
  - hlt → HALT; pc unchanged.
  - bra → FETCH. pc ← badr if BRA_REL=0, else pc + badr (badr read as signed two's complement, result modulo 2^PC_W). retired+1.
  - otherwise → EXECUTE.
- EXECUTE: exec_en=1 for one cycle.
  - mem_op=0: pc ← pc+1, retired+1, → FETCH.
  - mem_op=1: mem_req=1.
    - mem_ack same cycle: complete as mem_op=0.
    - else → MEM_WAIT, timeout counter cleared.
- MEM_WAIT: mem_req=1, exec_en=0.
  - On mem_ack: pc ← pc+1, retired+1, → FETCH.
  - Else counter+1. With MEM_TIMEOUT≠0, counter reaching MEM_TIMEOUT without ack → FAULT; a late ack in that same cycle is ignored.
- HALT: halted=1. On resume → pc ← pc+1, retired+1, → FETCH. hlt/bra ignored here.
- FAULT: fault=1, all other strobes 0. Sticky until rst.

Boundaries:
- pc+1 wraps 2^PC_W−1 → 0.
- retired wraps silently.
- Minimum instruction latency: 3 cycles (FETCH with ack, DECODE, EXECUTE); a taken branch costs 2.
- Acks outside their owning state are ignored.

Decomposition:
- Shared package: state-code localparams (reused by Control_Unit and benches) and the 3-bit state width constant.
- One natural sub-module: pc_unit. It holds the PC register, the absolute/relative target adder and the increment mux, with load/inc enables from the FSM.
- FSM, timeout counter and retired counter stay in cpu_sequencer.

Test Plan:
- Reset, then imem_ack tied 1, mem_op=0, bra=hlt=0 → st cycles 0,1,2,3,1…; pc 0→1→2 every 3 cycles; retired=2 after 2 instructions.
- BRA_REL=0, bra=1 in DECODE with badr=0x2A → next FETCH shows pc=0x2A, no exec_en pulse. BRA_REL=1, pc=5, badr=0x3FE (−2) → pc=3.
- mem_op=1, mem_ack delayed 4 cycles → mem_req high 5 cycles (EXECUTE + 4 MEM_WAIT); pc increments once; exec_en pulsed once.
- MEM_TIMEOUT=15, mem_ack never → FAULT after 15 MEM_WAIT cycles; fault=1 and st=6 until rst pulsed low, then pc=RESET_VEC.
- hlt=1 in DECODE at pc=7 → halted=1, pc stays 7 for 20 cycles; resume pulse → pc=8, FETCH.
- rst asserted while in MEM_WAIT → outputs clear immediately (async), st=0. pc=0x3FF non-branch instruction → pc wraps to 0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state width and state codes.
// Control_Unit and benches import the same codes so that the st output decodes consistently.
package cpu_sequencer_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_RESET    = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH    = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE   = 3'd2;
  localparam logic [ST_W-1:0] ST_EXECUTE  = 3'd3;
  localparam logic [ST_W-1:0] ST_MEM_WAIT = 3'd4;
  localparam logic [ST_W-1:0] ST_HALT     = 3'd5;
  localparam logic [ST_W-1:0] ST_FAULT    = 3'd6;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the sequencer and instrMem/dataMem/Control_Unit.
// The master side is the sequencer; the slave side is the memories and decode logic.
interface cpu_sequencer_if #(
  parameter int PC_W = 10
);
  logic            imem_req;
  logic            imem_ack;
  logic            ir_load;
  logic            cu_en;
  logic            bra;
  logic            hlt;
  logic [PC_W-1:0] badr;
  logic            mem_op;
  logic            exec_en;
  logic            mem_req;
  logic            mem_ack;
  logic            resume;

  modport master (
    output imem_req, ir_load, cu_en, exec_en, mem_req,
    input  imem_ack, bra, hlt, badr, mem_op, mem_ack, resume
  );

  modport slave (
    input  imem_req, ir_load, cu_en, exec_en, mem_req,
    output imem_ack, bra, hlt, badr, mem_op, mem_ack, resume
  );
endinterface

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter with branch-target formation (absolute or PC-relative) and increment.
// A branch load takes precedence over an increment; the FSM never raises both at once.
module cpu_sequencer_pc_unit #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter bit              BRA_REL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] badr,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] target;

  // Two's-complement offset addition is plain modulo-2^PC_W addition.
  assign target = BRA_REL ? (pc + badr) : badr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_VEC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle instruction sequencer: FSM, PC, memory-wait timeout and retired-instruction counter.
//   state    | meaning
//   RESET    | idle after reset, all strobes low
//   FETCH    | imem_req held until imem_ack, ir_load mirrors ack
//   DECODE   | one-cycle cu_en; resolves halt / branch / execute
//   EXECUTE  | one-cycle exec_en; mem_req when the instruction needs dataMem
//   MEM_WAIT | mem_req held until mem_ack or timeout
//   HALT     | halted until resume
//   FAULT    | memory timeout, sticky until reset
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int RESET_VEC   = 0,
  parameter bit BRA_REL     = 1'b0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  cpu_sequencer_if.master    bus,
  output logic [PC_W-1:0]    pc,
  output logic [ST_W-1:0]    st,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            to_clr;
  logic            to_inc;
  logic            pc_load;
  logic            pc_inc;
  logic            ret_inc;

  // The cycle that brings the wait count to MEM_TIMEOUT faults even if ack arrives in it.
  assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:    state_nxt = ST_FETCH;
      ST_FETCH:    if (bus.imem_ack) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (bus.hlt)      state_nxt = ST_HALT;
        else if (bus.bra) state_nxt = ST_FETCH;
        else              state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (!bus.mem_op || bus.mem_ack) state_nxt = ST_FETCH;
        else                            state_nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (to_hit)           state_nxt = ST_FAULT;
        else if (bus.mem_ack) state_nxt = ST_FETCH;
      end
      ST_HALT:     if (bus.resume) state_nxt = ST_FETCH;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.cu_en    = 1'b0;
    bus.exec_en  = 1'b0;
    bus.mem_req  = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    ret_inc      = 1'b0;
    to_clr       = 1'b0;
    to_inc       = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_load  = bus.imem_ack;
      end
      ST_DECODE: begin
        bus.cu_en = 1'b1;
        if (!bus.hlt && bus.bra) begin
          pc_load = 1'b1;
          ret_inc = 1'b1;
        end
      end
      ST_EXECUTE: begin
        bus.exec_en = 1'b1;
        bus.mem_req = bus.mem_op;
        if (!bus.mem_op || bus.mem_ack) begin
          pc_inc  = 1'b1;
          ret_inc = 1'b1;
        end else begin
          to_clr = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        bus.mem_req = 1'b1;
        if (!to_hit && bus.mem_ack) begin
          pc_inc  = 1'b1;
          ret_inc = 1'b1;
        end else if (!to_hit) begin
          to_inc = 1'b1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (bus.resume) begin
          pc_inc  = 1'b1;
          ret_inc = 1'b1;
        end
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (to_clr) begin
      to_cnt <= '0;
    end else if (to_inc) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (ret_inc) begin
      retired <= retired + CNT_W'(1);
    end
  end

  cpu_sequencer_pc_unit #(
    .PC_W      (PC_W),
    .RESET_VEC (PC_W'(RESET_VEC)),
    .BRA_REL   (BRA_REL)
  ) u_pc_unit (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .inc  (pc_inc),
    .badr (bus.badr),
    .pc   (pc)
  );

  assign st = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus hand sequences for
// timeout fault, halt/resume, async reset mid-wait and PC-relative branching.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(PC_W)) a_if ();
  cpu_sequencer_if #(.PC_W(PC_W)) b_if ();

  logic [PC_W-1:0]  pc_a, pc_b;
  logic [ST_W-1:0]  st_a, st_b;
  logic             halted_a, halted_b, fault_a, fault_b;
  logic [CNT_W-1:0] retired_a, retired_b;
  logic [6:0]       str_a;

  cpu_sequencer #(
    .PC_W(PC_W), .RESET_VEC(0), .BRA_REL(1'b0), .MEM_TIMEOUT(15), .CNT_W(CNT_W)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .pc(pc_a), .st(st_a),
    .halted(halted_a), .fault(fault_a), .retired(retired_a)
  );

  cpu_sequencer #(
    .PC_W(PC_W), .RESET_VEC(5), .BRA_REL(1'b1), .MEM_TIMEOUT(15), .CNT_W(CNT_W)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .pc(pc_b), .st(st_b),
    .halted(halted_b), .fault(fault_b), .retired(retired_b)
  );

  // {imem_req, ir_load, cu_en, exec_en, mem_req, halted, fault}
  assign str_a = {a_if.imem_req, a_if.ir_load, a_if.cu_en, a_if.exec_en,
                  a_if.mem_req, halted_a, fault_a};

  typedef struct {
    logic             imem_ack;
    logic             bra;
    logic             hlt;
    logic [PC_W-1:0]  badr;
    logic             mem_op;
    logic             mem_ack;
    logic             resume;
    logic [ST_W-1:0]  st;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ret;
    logic [6:0]       str;
  } vec_t;

  vec_t vt[32];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int ia, input int br, input int hl, input int ba,
                              input int mo, input int ma, input int rs, input int s,
                              input int p, input int r, input int sb);
    vec_t v;
    v.imem_ack = 1'(ia);
    v.bra      = 1'(br);
    v.hlt      = 1'(hl);
    v.badr     = PC_W'(ba);
    v.mem_op   = 1'(mo);
    v.mem_ack  = 1'(ma);
    v.resume   = 1'(rs);
    v.st       = ST_W'(s);
    v.pc       = PC_W'(p);
    v.ret      = CNT_W'(r);
    v.str      = 7'(sb);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.imem_ack = 1'b0; a_if.bra = 1'b0; a_if.hlt = 1'b0; a_if.badr = '0;
    a_if.mem_op = 1'b0; a_if.mem_ack = 1'b0; a_if.resume = 1'b0;
    b_if.imem_ack = 1'b0; b_if.bra = 1'b0; b_if.hlt = 1'b0; b_if.badr = '0;
    b_if.mem_op = 1'b0; b_if.mem_ack = 1'b0; b_if.resume = 1'b0;
  endtask

  task automatic drive_a(input vec_t v);
    a_if.imem_ack = v.imem_ack; a_if.bra = v.bra; a_if.hlt = v.hlt; a_if.badr = v.badr;
    a_if.mem_op = v.mem_op; a_if.mem_ack = v.mem_ack; a_if.resume = v.resume;
  endtask

  task automatic apply_reset();
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_st_a(input logic [ST_W-1:0] s, input string name);
    int n = 0;
    while (st_a !== s && n < 50) begin
      cyc();
      n++;
    end
    chk(name, 32'(st_a), 32'(s));
  endtask

  initial begin
    // ack, bra, hlt, badr, mem_op, mem_ack, resume | st, pc, retired, strobes
    vt[0]  = mk(0,0,0,'h000,0,0,0, 0,'h000,0,'b0000000);
    vt[1]  = mk(1,0,0,'h000,0,0,0, 1,'h000,0,'b1100000);
    vt[2]  = mk(0,0,0,'h000,0,0,0, 2,'h000,0,'b0010000);
    vt[3]  = mk(0,0,0,'h000,0,0,0, 3,'h000,0,'b0001000);
    vt[4]  = mk(1,0,0,'h000,0,0,0, 1,'h001,1,'b1100000);
    vt[5]  = mk(0,0,0,'h000,0,0,0, 2,'h001,1,'b0010000);
    vt[6]  = mk(0,0,0,'h000,0,0,0, 3,'h001,1,'b0001000);
    vt[7]  = mk(0,0,0,'h000,0,0,0, 1,'h002,2,'b1000000);
    vt[8]  = mk(0,0,0,'h000,0,1,1, 1,'h002,2,'b1000000);
    vt[9]  = mk(1,0,0,'h000,0,0,0, 1,'h002,2,'b1100000);
    vt[10] = mk(1,1,0,'h02A,0,0,0, 2,'h002,2,'b0010000);
    vt[11] = mk(1,0,0,'h000,0,0,0, 1,'h02A,3,'b1100000);
    vt[12] = mk(0,0,0,'h000,0,0,0, 2,'h02A,3,'b0010000);
    vt[13] = mk(0,0,0,'h000,1,0,0, 3,'h02A,3,'b0001100);
    vt[14] = mk(1,0,0,'h000,1,0,0, 4,'h02A,3,'b0000100);
    vt[15] = mk(0,0,0,'h000,1,0,0, 4,'h02A,3,'b0000100);
    vt[16] = mk(0,0,0,'h000,1,0,0, 4,'h02A,3,'b0000100);
    vt[17] = mk(0,0,0,'h000,1,1,0, 4,'h02A,3,'b0000100);
    vt[18] = mk(1,0,0,'h000,0,0,0, 1,'h02B,4,'b1100000);
    vt[19] = mk(0,0,0,'h000,0,0,0, 2,'h02B,4,'b0010000);
    vt[20] = mk(0,0,0,'h000,1,1,0, 3,'h02B,4,'b0001100);
    vt[21] = mk(1,0,0,'h000,0,0,0, 1,'h02C,5,'b1100000);
    vt[22] = mk(0,1,1,'h155,0,0,0, 2,'h02C,5,'b0010000);
    vt[23] = mk(0,1,1,'h155,0,0,0, 5,'h02C,5,'b0000010);
    vt[24] = mk(1,0,0,'h000,0,1,0, 5,'h02C,5,'b0000010);
    vt[25] = mk(0,0,0,'h000,0,0,1, 5,'h02C,5,'b0000010);
    vt[26] = mk(1,0,0,'h000,0,0,0, 1,'h02D,6,'b1100000);
    vt[27] = mk(0,1,0,'h3FF,0,0,0, 2,'h02D,6,'b0010000);
    vt[28] = mk(1,0,0,'h000,0,0,0, 1,'h3FF,7,'b1100000);
    vt[29] = mk(0,0,0,'h000,0,0,0, 2,'h3FF,7,'b0010000);
    vt[30] = mk(0,0,0,'h000,0,0,0, 3,'h3FF,7,'b0001000);
    vt[31] = mk(0,0,0,'h000,0,0,0, 1,'h000,8,'b1000000);

    idle_all();
    #12;
    chk("reset st_a", 32'(st_a), 32'(ST_RESET));
    chk("reset pc_a", 32'(pc_a), 32'h0);
    chk("reset retired_a", 32'(retired_a), 32'h0);
    chk("reset strobes_a", 32'(str_a), 32'h0);
    chk("reset pc_b", 32'(pc_b), 32'h5);

    cyc();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive_a(vt[i]);
      @(negedge clk);
      chk($sformatf("vec%0d st", i), 32'(st_a), 32'(vt[i].st));
      chk($sformatf("vec%0d pc", i), 32'(pc_a), 32'(vt[i].pc));
      chk($sformatf("vec%0d retired", i), 32'(retired_a), 32'(vt[i].ret));
      chk($sformatf("vec%0d strobes", i), 32'(str_a), 32'(vt[i].str));
      cyc();
    end

    // Timeout: 14 silent MEM_WAIT cycles, ack in the 15th must lose to the fault.
    begin
      int waits = 0;
      apply_reset();
      a_if.imem_ack = 1'b1;
      wait_st_a(ST_EXECUTE, "to first exec");
      cyc();
      a_if.mem_op = 1'b1;
      wait_st_a(ST_EXECUTE, "to mem exec");
      chk("to pc before wait", 32'(pc_a), 32'h1);
      cyc();
      while (st_a === ST_MEM_WAIT && waits < 30) begin
        waits++;
        if (waits == 15) a_if.mem_ack = 1'b1;
        cyc();
      end
      chk("to wait cycles", 32'(waits), 32'd15);
      chk("to st fault", 32'(st_a), 32'(ST_FAULT));
      a_if.resume = 1'b1; a_if.bra = 1'b1; a_if.hlt = 1'b1;
      for (int k = 0; k < 8; k++) begin
        cyc();
        chk($sformatf("fault sticky st %0d", k), 32'(st_a), 32'(ST_FAULT));
        chk($sformatf("fault sticky strobes %0d", k), 32'(str_a), 32'b0000001);
      end
      chk("fault pc held", 32'(pc_a), 32'h1);
      rst = 1'b0;
      #1;
      chk("fault rst pc", 32'(pc_a), 32'h0);
      chk("fault rst st", 32'(st_a), 32'(ST_RESET));
      chk("fault rst flag", 32'(fault_a), 32'h0);
      #1;
      rst = 1'b1;
    end

    // Halt at pc=7 for 20 cycles, then resume.
    begin
      int held = 0;
      apply_reset();
      a_if.imem_ack = 1'b1;
      for (int k = 0; k < 7; k++) begin
        wait_st_a(ST_EXECUTE, $sformatf("halt run exec %0d", k));
        cyc();
      end
      chk("halt pc before", 32'(pc_a), 32'h7);
      a_if.hlt = 1'b1;
      cyc();
      chk("halt decode st", 32'(st_a), 32'(ST_DECODE));
      cyc();
      a_if.hlt = 1'b0;
      chk("halt st", 32'(st_a), 32'(ST_HALT));
      for (int k = 0; k < 20; k++) begin
        if (halted_a === 1'b1 && pc_a === 10'h7 && st_a === ST_HALT) held++;
        cyc();
      end
      chk("halt held cycles", 32'(held), 32'd20);
      a_if.resume = 1'b1;
      cyc();
      a_if.resume = 1'b0;
      chk("resume st", 32'(st_a), 32'(ST_FETCH));
      chk("resume pc", 32'(pc_a), 32'h8);
      chk("resume retired", 32'(retired_a), 32'h8);
    end

    // Async reset while waiting on dataMem.
    apply_reset();
    a_if.imem_ack = 1'b1;
    wait_st_a(ST_EXECUTE, "arst first exec");
    cyc();
    a_if.mem_op = 1'b1;
    wait_st_a(ST_MEM_WAIT, "arst to mem_wait");
    cyc();
    chk("arst mem_req", 32'(a_if.mem_req), 32'h1);
    chk("arst pc before", 32'(pc_a), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst st", 32'(st_a), 32'(ST_RESET));
    chk("arst pc", 32'(pc_a), 32'h0);
    chk("arst retired", 32'(retired_a), 32'h0);
    chk("arst strobes", 32'(str_a), 32'h0);
    #1;
    rst = 1'b1;

    // PC-relative branches on the second instance (reset vector 5).
    apply_reset();
    chk("rel reset pc", 32'(pc_b), 32'h5);
    b_if.imem_ack = 1'b1;
    b_if.bra = 1'b1;
    b_if.badr = 10'h3FE;
    cyc();
    cyc();
    chk("rel decode st", 32'(st_b), 32'(ST_DECODE));
    cyc();
    chk("rel back st", 32'(st_b), 32'(ST_FETCH));
    chk("rel back pc", 32'(pc_b), 32'h3);
    b_if.badr = 10'h3FC;
    cyc();
    cyc();
    chk("rel wrap pc", 32'(pc_b), 32'h3FF);
    chk("rel retired", 32'(retired_b), 32'h2);
    chk("rel no exec", 32'(b_if.exec_en), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
